// File: rtl/bounce_generator_pkg.sv
// Shared constants for the contact-bounce emulator: LFSR geometry, FSM encoding, default seed.
package bounce_generator_pkg;

  localparam int          LFSR_W       = 16;
  // Taps x^16 + x^14 + x^13 + x^11 + 1 mapped onto bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_BOUNCE = 1'b1
  } bounce_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_generator_channel.sv
// One bounce channel: follows a commanded level, bouncing pseudo-randomly for a fixed
// number of cycles after every commanded change.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | output settled at target; waiting for clean to differ
// ST_BOUNCE | output glitching; settles to target when bounce_cnt hits 0
module bounce_channel
  import bounce_generator_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 20,
  parameter int TOGGLE_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clean_i,
  input  logic lfsr_bit_i,
  output logic glitchy_o,
  output logic bouncing_o
);

  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TOGGLE_PERIOD + 1);
  localparam logic [BW-1:0] BOUNCE_LOAD = BW'(BOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LOAD  = PW'(TOGGLE_PERIOD - 1);

  bounce_state_e   state_q;
  logic            target_q;
  logic            glitchy_q;
  logic            bouncing_q;
  logic [BW-1:0]   bounce_cnt_q;
  logic [PW-1:0]   phase_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= 1'b0;
      glitchy_q    <= 1'b0;
      bouncing_q   <= 1'b0;
      bounce_cnt_q <= '0;
      phase_cnt_q  <= '0;
    end else if (clean_i != target_q) begin
      // New command (from IDLE or a reversal mid-bounce): forced first glitch, reload timers.
      state_q      <= ST_BOUNCE;
      target_q     <= clean_i;
      glitchy_q    <= ~glitchy_q;
      bouncing_q   <= 1'b1;
      bounce_cnt_q <= BOUNCE_LOAD;
      phase_cnt_q  <= PHASE_LOAD;
    end else if (state_q == ST_BOUNCE) begin
      if (bounce_cnt_q == '0) begin
        state_q    <= ST_IDLE;
        glitchy_q  <= target_q;
        bouncing_q <= 1'b0;
      end else begin
        bounce_cnt_q <= bounce_cnt_q - 1'b1;
        if (phase_cnt_q == '0) begin
          glitchy_q   <= glitchy_q ^ lfsr_bit_i;
          phase_cnt_q <= PHASE_LOAD;
        end else begin
          phase_cnt_q <= phase_cnt_q - 1'b1;
        end
      end
    end
  end

  assign glitchy_o  = glitchy_q;
  assign bouncing_o = bouncing_q;

endmodule

// File: rtl/bounce_generator.sv
// Multi-channel contact-bounce emulator: one shared free-running LFSR feeding
// independent per-channel bounce FSMs.
module bounce_generator
  import bounce_generator_pkg::*;
#(
  parameter int          width         = 1,
  parameter int          bounce_cycles = 20,
  parameter int          toggle_period = 2,
  parameter logic [15:0] lfsr_seed     = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] clean_signal,
  output logic [width-1:0] glitchy_signal,
  output logic [width-1:0] bouncing
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= lfsr_seed;
    else     lfsr_q <= lfsr_d;
  end

  for (genvar i = 0; i < width; i++) begin : g_chan
    bounce_channel #(
      .BOUNCE_CYCLES (bounce_cycles),
      .TOGGLE_PERIOD (toggle_period)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clean_i    (clean_signal[i]),
      .lfsr_bit_i (lfsr_q[i]),
      .glitchy_o  (glitchy_signal[i]),
      .bouncing_o (bouncing[i])
    );
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator (2 channels, 20 bounce cycles, decision every 2 cycles).
module tb_bounce_generator;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clean_signal;
  logic [1:0] glitchy_signal;
  logic [1:0] bouncing;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_g;
  logic [1:0]  cap  [0:255];
  logic [1:0]  rec1 [0:29];

  bounce_generator #(
    .width         (2),
    .bounce_cycles (20),
    .toggle_period (2),
    .lfsr_seed     (SEED)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clean_signal   (clean_signal),
    .glitchy_signal (glitchy_signal),
    .bouncing       (bouncing)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: holds the value the DUT will use at the next posedge.
  always @(posedge clk) m_lfsr <= rst ? SEED : step(m_lfsr);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs ncyc clocks with clean_signal held; channels in mask see a change at the first edge.
  task automatic run_bounce(input string tag, input logic [1:0] mask, input int ncyc);
    logic [15:0] l;
    logic [1:0]  g0;
    logic [1:0]  eb;
    l  = m_lfsr;
    g0 = exp_g;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      if (j > 0) l = step(l);
      for (int ch = 0; ch < 2; ch++) begin
        eb[ch] = mask[ch] && (j < 20);
        if (mask[ch]) begin
          if (j == 0)                        exp_g[ch] = ~g0[ch];
          else if (j < 20 && (j % 2) == 0)   exp_g[ch] = exp_g[ch] ^ l[ch];
          else if (j == 20)                  exp_g[ch] = clean_signal[ch];
        end
      end
      cap[j] = glitchy_signal;
      check({tag, " glitchy"},  {14'd0, glitchy_signal}, {14'd0, exp_g});
      check({tag, " bouncing"}, {14'd0, bouncing},       {14'd0, eb});
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      check("rst glitchy",  {14'd0, glitchy_signal}, 16'd0);
      check("rst bouncing", {14'd0, bouncing},       16'd0);
    end
    exp_g = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    clean_signal = 2'b11;
    exp_g = 2'b00;
    reset_cycles(3);

    // Release with clean=11: both channels start bouncing on the first free edge.
    @(negedge clk); rst = 1'b0;
    run_bounce("release", 2'b11, 25);
    @(negedge clk); clean_signal = 2'b00;
    run_bounce("fall both", 2'b11, 25);

    // Baseline single press after a fresh reset and 5 idle cycles.
    @(negedge clk); rst = 1'b1;
    reset_cycles(2);
    @(negedge clk); rst = 1'b0;
    run_bounce("idle", 2'b00, 5);
    @(negedge clk); clean_signal = 2'b01;
    run_bounce("press", 2'b01, 220);
    for (int j = 0; j < 30; j++) rec1[j] = cap[j];

    @(negedge clk); clean_signal = 2'b00;
    run_bounce("release0", 2'b01, 25);

    // Reversal ten cycles into a bounce.
    @(negedge clk); clean_signal = 2'b01;
    run_bounce("rev start", 2'b01, 10);
    @(negedge clk); clean_signal = 2'b00;
    run_bounce("rev back", 2'b01, 40);

    @(negedge clk); clean_signal = 2'b11;
    run_bounce("simul up", 2'b11, 25);
    @(negedge clk); clean_signal = 2'b00;
    run_bounce("simul down", 2'b11, 25);

    // Reset mid-bounce (at press+7), then replay the baseline press.
    @(negedge clk); clean_signal = 2'b01;
    run_bounce("abort", 2'b01, 7);
    @(negedge clk); rst = 1'b1; clean_signal = 2'b00;
    reset_cycles(2);
    @(negedge clk); rst = 1'b0;
    run_bounce("idle2", 2'b00, 5);
    @(negedge clk); clean_signal = 2'b01;
    run_bounce("replay", 2'b01, 30);
    for (int j = 0; j < 30; j++)
      check("replay identical", {14'd0, cap[j]}, {14'd0, rec1[j]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
